// File: rtl/mu0_sequencer.sv
// MU0 control-phase sequencer: drives FETCH/EXEC1/EXEC2 strobes, owns skipstatus,
// halts on STP and keeps a retired-instruction count for the debug display.
module mu0_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [3:0]       IR_OP,
    input  logic             EXTRA,
    input  logic             SKIP_REQ,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             IR_EN,
    output logic             skipstatus,
    output logic             RETIRE,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_STP = 4'b0111;

    state_t state;
    state_t state_next;
    logic   stp_halt;
    logic   last_exec;

    // A nullified STP falls through and retires like any other instruction.
    assign stp_halt  = (state == S_EXEC1) && (IR_OP == OP_STP) && !skipstatus;
    assign last_exec = (state == S_EXEC2) || ((state == S_EXEC1) && !stp_halt && !EXTRA);

    assign RETIRE = last_exec;
    assign IR_EN  = FETCH;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (RUN || STEP) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_EXEC1;
            end
            S_EXEC1: begin
                if (stp_halt) begin
                    state_next = S_HALT;
                end else if (EXTRA) begin
                    state_next = S_EXEC2;
                end else begin
                    state_next = RUN ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC2: begin
                state_next = RUN ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Phase strobes are registered from the next state so they always match the state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= S_IDLE;
            FETCH       <= 1'b0;
            EXEC1       <= 1'b0;
            EXEC2       <= 1'b0;
            HALTED      <= 1'b0;
            skipstatus  <= 1'b0;
            INSTR_COUNT <= '0;
        end else begin
            state  <= state_next;
            FETCH  <= (state_next == S_FETCH);
            EXEC1  <= (state_next == S_EXEC1);
            EXEC2  <= (state_next == S_EXEC2);
            HALTED <= (state_next == S_HALT);
            if (last_exec) begin
                INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
                skipstatus  <= !skipstatus && SKIP_REQ;
            end
        end
    end

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed self-checking bench for mu0_sequencer, built with a 4-bit counter so wrap is reachable.
module tb_mu0_sequencer;

    localparam int CNT_W = 4;

    // Packed view: {FETCH, EXEC1, EXEC2, IR_EN, skipstatus, RETIRE, HALTED}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_F     = 7'b1001000;
    localparam logic [6:0] O_FS    = 7'b1001100;
    localparam logic [6:0] O_E1    = 7'b0100000;
    localparam logic [6:0] O_E1R   = 7'b0100010;
    localparam logic [6:0] O_E1SR  = 7'b0100110;
    localparam logic [6:0] O_E2R   = 7'b0010010;
    localparam logic [6:0] O_HALT  = 7'b0000001;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STP = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1000;

    logic             clock;
    logic             reset;
    logic             run;
    logic             step;
    logic [3:0]       ir_op;
    logic             extra;
    logic             skip_req;
    logic             fetch;
    logic             exec1;
    logic             exec2;
    logic             ir_en;
    logic             skipstatus;
    logic             retire;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    logic [6:0]       obs;
    logic [CNT_W-1:0] exp_cnt;

    int checks = 0;
    int errors = 0;

    assign obs = {fetch, exec1, exec2, ir_en, skipstatus, retire, halted};

    mu0_sequencer #(.CNT_W(CNT_W)) dut (
        .CLOCK       (clock),
        .RESET       (reset),
        .RUN         (run),
        .STEP        (step),
        .IR_OP       (ir_op),
        .EXTRA       (extra),
        .SKIP_REQ    (skip_req),
        .FETCH       (fetch),
        .EXEC1       (exec1),
        .EXEC2       (exec2),
        .IR_EN       (ir_en),
        .skipstatus  (skipstatus),
        .RETIRE      (retire),
        .HALTED      (halted),
        .INSTR_COUNT (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1ns after the edge; outputs are sampled 1ns after that.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; step = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, O_IDLE); end
        checks++;
        if (instr_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", instr_count); end
        step = 1'b0;
    endtask

    task automatic test_run_ldi();
        ir_op = OP_LDI; extra = 1'b0; run = 1'b1;
        exp_cnt = '0;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL ldi_cycle0: got %b expected %b", obs, O_IDLE); end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            checks++;
            if (obs !== O_F || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL ldi_fetch%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_F, exp_cnt);
            end
            next_cycle();
            if (k == 2) run = 1'b0;
            #1;
            checks++;
            if (obs !== O_E1R || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL ldi_exec1_%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_E1R, exp_cnt);
            end
            exp_cnt = exp_cnt + 1'b1;
        end
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== exp_cnt) begin
            errors++; $display("[TB] FAIL ldi_idle: got %b/%0d expected %b/%0d", obs, instr_count, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_run_lda();
        ir_op = OP_LDA; extra = 1'b1; run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            checks++;
            if (obs !== O_F || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL lda_fetch%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_F, exp_cnt);
            end
            next_cycle();
            if (k == 1) run = 1'b0;
            #1;
            checks++;
            if (obs !== O_E1) begin errors++; $display("[TB] FAIL lda_exec1_%0d: got %b expected %b", k, obs, O_E1); end
            next_cycle(); #1;
            checks++;
            if (obs !== O_E2R || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL lda_exec2_%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_E2R, exp_cnt);
            end
            exp_cnt = exp_cnt + 1'b1;
        end
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== exp_cnt) begin
            errors++; $display("[TB] FAIL lda_idle: got %b/%0d expected %b/%0d", obs, instr_count, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_step();
        run = 1'b0; extra = 1'b1; ir_op = OP_LDA;
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        #1;
        checks++;
        if (obs !== O_F) begin errors++; $display("[TB] FAIL step_fetch: got %b expected %b", obs, O_F); end
        next_cycle();
        step = 1'b1;
        #1;
        checks++;
        if (obs !== O_E1) begin errors++; $display("[TB] FAIL step_exec1: got %b expected %b", obs, O_E1); end
        next_cycle();
        step = 1'b0;
        #1;
        checks++;
        if (obs !== O_E2R) begin errors++; $display("[TB] FAIL step_exec2: got %b expected %b", obs, O_E2R); end
        exp_cnt = exp_cnt + 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            checks++;
            if (obs !== O_IDLE || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL step_idle%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_IDLE, exp_cnt);
            end
        end
    endtask

    task automatic test_skip();
        run = 1'b1; extra = 1'b0; ir_op = OP_LDI;
        next_cycle(); #1;
        checks++;
        if (obs !== O_F) begin errors++; $display("[TB] FAIL skip_a_fetch: got %b expected %b", obs, O_F); end
        next_cycle();
        skip_req = 1'b1;
        #1;
        checks++;
        if (obs !== O_E1R) begin errors++; $display("[TB] FAIL skip_a_exec1: got %b expected %b", obs, O_E1R); end
        exp_cnt = exp_cnt + 1'b1;
        next_cycle();
        skip_req = 1'b0; ir_op = OP_STP;
        #1;
        checks++;
        if (obs !== O_FS) begin errors++; $display("[TB] FAIL skip_b_fetch: got %b expected %b", obs, O_FS); end
        next_cycle();
        skip_req = 1'b1;
        #1;
        checks++;
        if (obs !== O_E1SR) begin errors++; $display("[TB] FAIL skip_b_exec1: got %b expected %b", obs, O_E1SR); end
        exp_cnt = exp_cnt + 1'b1;
        next_cycle();
        skip_req = 1'b0; ir_op = OP_LDI;
        #1;
        checks++;
        if (obs !== O_F || instr_count !== exp_cnt) begin
            errors++; $display("[TB] FAIL skip_c_fetch: got %b/%0d expected %b/%0d", obs, instr_count, O_F, exp_cnt);
        end
        next_cycle();
        run = 1'b0;
        #1;
        checks++;
        if (obs !== O_E1R) begin errors++; $display("[TB] FAIL skip_c_exec1: got %b expected %b", obs, O_E1R); end
        exp_cnt = exp_cnt + 1'b1;
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== exp_cnt) begin
            errors++; $display("[TB] FAIL skip_idle: got %b/%0d expected %b/%0d", obs, instr_count, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_halt();
        run = 1'b1; extra = 1'b0; ir_op = OP_STP;
        next_cycle(); #1;
        checks++;
        if (obs !== O_F) begin errors++; $display("[TB] FAIL halt_fetch: got %b expected %b", obs, O_F); end
        next_cycle(); #1;
        checks++;
        if (obs !== O_E1) begin errors++; $display("[TB] FAIL halt_exec1: got %b expected %b", obs, O_E1); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            run = k[0]; step = ~k[0];
            #1;
            checks++;
            if (obs !== O_HALT || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL halt_hold%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_HALT, exp_cnt);
            end
        end
        reset = 1'b1; run = 1'b0; step = 1'b0;
        next_cycle();
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== exp_cnt) begin
            errors++; $display("[TB] FAIL halt_reset: got %b/%0d expected %b/%0d", obs, instr_count, O_IDLE, exp_cnt);
        end
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL halt_restart_idle: got %b expected %b", obs, O_IDLE); end
    endtask

    task automatic test_wrap();
        run = 1'b1; extra = 1'b0; ir_op = OP_LDI;
        for (int k = 0; k < 17; k++) begin
            next_cycle(); #1;
            checks++;
            if (obs !== O_F || instr_count !== exp_cnt) begin
                errors++; $display("[TB] FAIL wrap_fetch%0d: got %b/%0d expected %b/%0d", k, obs, instr_count, O_F, exp_cnt);
            end
            next_cycle();
            if (k == 16) run = 1'b0;
            #1;
            exp_cnt = exp_cnt + 1'b1;
        end
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== 4'd1) begin
            errors++; $display("[TB] FAIL wrap_final: got %b/%0d expected %b/1", obs, instr_count, O_IDLE);
        end
    endtask

    task automatic test_reset_exec2();
        run = 1'b1; extra = 1'b1; ir_op = OP_LDA;
        next_cycle();
        next_cycle();
        next_cycle(); #1;
        checks++;
        if (obs !== O_E2R) begin errors++; $display("[TB] FAIL rst2_exec2: got %b expected %b", obs, O_E2R); end
        reset = 1'b1;
        next_cycle(); #1;
        checks++;
        if (obs !== O_IDLE || instr_count !== 4'd0) begin
            errors++; $display("[TB] FAIL rst2_cleared: got %b/%0d expected %b/0", obs, instr_count, O_IDLE);
        end
        reset = 1'b0; run = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0;
        ir_op = OP_LDI; extra = 1'b0; skip_req = 1'b0;
        exp_cnt = '0;
        test_reset();
        test_run_ldi();
        test_run_lda();
        test_step();
        test_skip();
        test_halt();
        test_wrap();
        test_reset_exec2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mu0_sequencer.md
Name: mu0_sequencer

Overview:
- Control-phase sequencer directly upstream of the MU0 instruction decoder.
- Generates the one-hot FETCH/EXEC1/EXEC2 phase strobes and the IR load enable.
- Consumes the decoder's EXTRA request to insert EXEC2, owns the skipstatus register, and halts on STP.
- Provides run/single-step control, a retired-instruction counter and a halt indicator for the debug/display logic.

Parameters:
- CNT_W, 16, width of INSTR_COUNT.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- RUN  input  1  level; 1 = free-running execution.
- STEP  input  1  single-cycle pulse; executes exactly one instruction while RUN=0.
- IR_OP  input  4  IR[15:12] from the instruction register.
- EXTRA  input  1  from decoder; current instruction needs EXEC2 (only meaningful in EXEC1).
- SKIP_REQ  input  1  from the condition unit; skip the next instruction; sampled only on the last execute cycle.
- FETCH  output  1  fetch phase strobe.
- EXEC1  output  1  first execute phase strobe.
- EXEC2  output  1  second execute phase strobe.
- IR_EN  output  1  IR load enable; equals FETCH.
- skipstatus  output  1  current instruction is nullified; feeds the decoder.
- RETIRE  output  1  one-cycle pulse on the last execute cycle of every instruction, skipped ones included.
- HALTED  output  1  core stopped by STP.
- INSTR_COUNT  output  CNT_W  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, HALT.
  - FETCH, EXEC1 and EXEC2 outputs are registered one-hot decodes of the state.
  - All three are 0 in IDLE and HALT.
- Reset, taking priority over everything: state=IDLE; FETCH=EXEC1=EXEC2=IR_EN=0; skipstatus=0; RETIRE=0; HALTED=0; INSTR_COUNT=0. Reset mid-instruction abandons it with no retire.
- IDLE:
  - Go to FETCH if RUN=1 or STEP=1.
  - Otherwise remain in IDLE.
  - A STEP asserted outside IDLE is ignored; it is not queued.
- FETCH: always go to EXEC1 on the next cycle.
- EXEC1:
  - If IR_OP=4'b0111 (STP) and skipstatus=0, go to HALT. STP does not retire.
  - Else if EXTRA=1, go to EXEC2.
  - Else this is the last execute cycle.
- EXEC2: always the last execute cycle.
- Last execute cycle:
  - RETIRE=1 combinationally in that cycle.
  - INSTR_COUNT increments at the end of that cycle, wrapping from 2^CNT_W-1 to 0.
  - Next state is FETCH if RUN=1, else IDLE. This applies to single-step, and to RUN dropped mid-instruction, which finishes the current instruction first.
- Skip rules:
  - At the end of the last execute cycle: if skipstatus=0, skipstatus <= SKIP_REQ; if skipstatus=1, skipstatus <= 0.
  - A skipped instruction can never re-arm skip, and SKIP_REQ at any other time is ignored.
  - A skipped instruction still runs its full FETCH/EXEC1[/EXEC2] sequence, because EXTRA is still honoured.
  - A skipped STP does not halt and retires as normal.
- HALT:
  - HALTED=1 from the cycle after the STP EXEC1 onwards.
  - HALT is left only by RESET; RUN and STEP are ignored.
- Cycle latency:
  - 2 cycles per instruction without EXEC2, 3 with.
  - From IDLE with RUN high, FETCH is asserted 1 cycle after the RUN sample.

Test Plan:
- Reset held, then released with RUN=1 and EXTRA=0, IR_OP=4'b1000 (LDI) → FETCH in cycle 1, EXEC1 in cycle 2, RETIRE in cycle 2, INSTR_COUNT=1 after cycle 2; the pattern repeats every 2 cycles.
- RUN=1, EXTRA=1 in EXEC1, IR_OP=4'b0000 (LDA) → FETCH, EXEC1, EXEC2 sequence; RETIRE only in EXEC2; 3 cycles per instruction.
- RUN=0, single STEP pulse, EXTRA=1 → exactly FETCH, EXEC1, EXEC2, then IDLE; INSTR_COUNT +1. A second STEP pulse during EXEC1 has no effect.
- SKIP_REQ=1 on the last execute cycle of instruction A; instruction B is STP (IR_OP=4'b0111) → skipstatus=1 throughout B; no halt; B retires; skipstatus=0 for C. SKIP_REQ=1 during B is ignored.
- STP with skipstatus=0 → HALTED=1 and state HALT; INSTR_COUNT unchanged; RUN/STEP toggling keeps HALT. RESET clears HALTED and restarts from IDLE.
- CNT_W=4, run 17 non-STP instructions → INSTR_COUNT wraps 15→0 and ends at 1. Asserting RESET during EXEC2 → next cycle all outputs 0, count 0.
